// File: rtl/ib_lut_addr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ib_lut_addr_sched
//  Description : Splits a batch of (y0, y1) lookups into LUT page/bank
//                addresses and issues them, limiting accesses per bank per
//                cycle. Optional macro IB_SCHED_CONFLICT_CNT_EN enables the
//                bank-conflict replay counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ib_lut_addr_sched #(
    parameter int PORT_NUM        = 4,
    parameter int Y0_BW           = 2,
    parameter int Y1_BW           = 2,
    parameter int BANK_BW         = 1,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int BANK_RD_PORTS   = 2,
    localparam int FRAME_BW       = $clog2(MULTI_FRAME_NUM),
    localparam int PAGE_BW        = FRAME_BW + Y0_BW + Y1_BW - BANK_BW
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PORT_NUM-1:0]           in_en,
    input  logic [FRAME_BW-1:0]           frame_id,
    input  logic [PORT_NUM*Y0_BW-1:0]     y0_in,
    input  logic [PORT_NUM*Y1_BW-1:0]     y1_in,
    output logic [PORT_NUM-1:0]           out_valid,
    output logic [PORT_NUM*PAGE_BW-1:0]   page_addr,
    output logic [PORT_NUM*BANK_BW-1:0]   bank_addr,
    output logic                          out_last,
    output logic [15:0]                   conflict_cnt
);

    localparam int c_NUM_BANK = 2 ** BANK_BW;
    localparam int c_CNT_W    = $clog2(PORT_NUM + BANK_RD_PORTS + 1);
    localparam logic [c_CNT_W-1:0] c_RD_LIMIT = c_CNT_W'(BANK_RD_PORTS);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ISSUE = 1'b1;

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [PORT_NUM-1:0]         r_pending;
    logic [PORT_NUM-1:0]         w_pending_nxt;
    logic [PORT_NUM-1:0]         w_grant;
    logic [PORT_NUM-1:0]         w_remain;
    logic                        w_issue;
    logic                        w_done;
    logic                        w_accept;

    logic [FRAME_BW-1:0]         r_frame;
    logic [PORT_NUM*Y0_BW-1:0]   r_y0;
    logic [PORT_NUM*Y1_BW-1:0]   r_y1;

    logic [PORT_NUM*PAGE_BW-1:0] w_page;
    logic [PORT_NUM*BANK_BW-1:0] w_bank;
    logic [PORT_NUM*PAGE_BW-1:0] r_page;
    logic [PORT_NUM*BANK_BW-1:0] r_bank;
    logic [PORT_NUM-1:0]         r_out_valid;
    logic                        r_out_last;

    logic [c_CNT_W-1:0]          w_bank_cnt [c_NUM_BANK];
    logic [BANK_BW-1:0]          w_sel;

    // Per-lane address split of the latched batch
    generate
        for (genvar p = 0; p < PORT_NUM; p++) begin : g_lane
            assign w_page[p*PAGE_BW +: PAGE_BW] = {r_frame,
                                                   r_y0[p*Y0_BW +: Y0_BW],
                                                   r_y1[p*Y1_BW+BANK_BW +: Y1_BW-BANK_BW]};
            assign w_bank[p*BANK_BW +: BANK_BW] = r_y1[p*Y1_BW +: BANK_BW];
        end
    endgenerate

    // Lowest-index-first arbitration, each bank capped at BANK_RD_PORTS grants
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        for (int b = 0; b < c_NUM_BANK; b++) begin
            w_bank_cnt[b] = '0;
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            w_sel = w_bank[p*BANK_BW +: BANK_BW];
            if (r_pending[p] && (w_bank_cnt[w_sel] < c_RD_LIMIT)) begin
                w_grant[p]        = 1'b1;
                w_bank_cnt[w_sel] = w_bank_cnt[w_sel] + c_CNT_W'(1);
            end
        end
    end

    assign w_issue  = (r_state == c_ST_ISSUE);
    assign w_remain = r_pending & ~w_grant;
    assign w_done   = (w_remain == '0);
    assign in_ready = !rst && ((r_state == c_ST_IDLE) || w_done);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = c_ST_ISSUE;
                    w_pending_nxt = in_en;
                end
            end
            c_ST_ISSUE: begin
                w_pending_nxt = w_remain;
                if (w_accept) begin
                    w_state_nxt   = c_ST_ISSUE;
                    w_pending_nxt = in_en;
                end else if (w_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pending <= '0;
            r_frame   <= '0;
            r_y0      <= '0;
            r_y1      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_frame <= frame_id;
                r_y0    <= y0_in;
                r_y1    <= y1_in;
            end
        end
    end

    // Non-granted lanes keep their last issued address
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_last  <= 1'b0;
            r_page      <= '0;
            r_bank      <= '0;
        end else begin
            r_out_valid <= w_issue ? w_grant : '0;
            r_out_last  <= w_issue && w_done;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (w_issue && w_grant[p]) begin
                    r_page[p*PAGE_BW +: PAGE_BW] <= w_page[p*PAGE_BW +: PAGE_BW];
                    r_bank[p*BANK_BW +: BANK_BW] <= w_bank[p*BANK_BW +: BANK_BW];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign page_addr = r_page;
    assign bank_addr = r_bank;

`ifdef IB_SCHED_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_issue && !w_done && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
